// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the fetch queue: the NOP encoding, the RISC-V opcodes
// the static predictor recognises, the queue entry layout and the
// immediate-extraction helpers. The predictor helpers are used only when the
// design is built with PREDICT_EN defined.
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

   localparam int unsigned FQ_XLEN   = 32;
   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [6:0]  OP_JAL    = 7'b110_1111;
   localparam logic [6:0]  OP_BRANCH = 7'b110_0011;

   typedef struct packed {
      logic [31:0]         instr;
      logic [FQ_XLEN-1:0]  pc;
      logic                pred_taken;
      logic [FQ_XLEN-1:0]  pred_target;
   } fq_entry_t;

   // Sign-extended J-type immediate (JAL offset)
   function automatic logic [31:0] j_imm(input logic [31:0] instr);
      return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

   // Sign-extended B-type immediate (conditional branch offset)
   function automatic logic [31:0] b_imm(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_queue_chk.sv
// ---------------------------------------------------------------------------
// fq_chk
// Simulation checker for the fetch queue.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       entry written to the queue this cycle
//   full       queue holds DEPTH entries
// ---------------------------------------------------------------------------
module fq_chk (
   input logic clk,
   input logic rst,
   input logic push,
   input logic full
);

   // A push into a full queue means the request credit accounting is broken
   push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/fetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// fq_fifo
// DEPTH-entry circular buffer of fetch entries with synchronous clear.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             drop all entries (takes priority over push/pop)
//   push, push_data   write one entry at the tail
//   pop               retire the head entry (ignored when empty)
//   head              current head entry (contents undefined when empty)
//   count             number of valid entries, 0..DEPTH
//   full              count == DEPTH
// ---------------------------------------------------------------------------
module fq_fifo
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  fq_entry_t              push_data,
   input  logic                   pop,
   output fq_entry_t              head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);

   localparam int unsigned    AW      = $clog2(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE = AW'(1'b1);
   localparam logic [AW:0]    CNT_ONE = (AW+1)'(1'b1);

   fq_entry_t      mem_r [DEPTH];
   logic [AW-1:0]  wr_ptr_r;
   logic [AW-1:0]  rd_ptr_r;
   logic [AW:0]    count_r;
   logic           do_push_s;
   logic           do_pop_s;

   // Qualified strobes and head/status view
   always_comb begin
      do_push_s = push && !clear;
      do_pop_s  = pop && !clear && (count_r != {(AW+1){1'b0}});
      head      = mem_r[rd_ptr_r];
      count     = count_r;
      full      = (count_r == (AW+1)'(DEPTH));
   end

   // Entry storage; slots outside the valid window are don't-care
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else if (clear) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Sequential-PC fetch front end. Issues in-order instruction-memory reads,
// buffers returned words with their PC in a DEPTH-entry queue and presents
// them to decode over valid/ready. A redirect flushes the queue, restarts
// fetch at redirect_pc and discards every response still in flight.
// Optional build macro PREDICT_EN adds a static BTFN predictor applied when an
// entry is pushed (taken JAL / backward branch re-steers fetch internally).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   redirect_valid/redirect_pc  flush and restart fetch at redirect_pc
//   imem_req/imem_addr          read request, held until imem_gnt
//   imem_gnt                    request accepted this cycle
//   imem_rvalid/imem_rdata      in-order read response
//   out_valid/out_ready         decode handshake for the head entry
//   out_instr/out_pc/out_pc_p4  head word (NOP when invalid), its PC, PC+4
//   out_pred_taken/target       head prediction (not-taken / PC+4 by default)
// ---------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter int unsigned      MAX_OUT  = 2,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_p4,
   output logic            out_pred_taken,
   output logic [XLEN-1:0] out_pred_target
);

   localparam int unsigned     CW      = $clog2(DEPTH) + 1;
   localparam int unsigned     OW      = $clog2(MAX_OUT + 1);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);
   localparam logic [OW-1:0]   OUT_ONE = OW'(1'b1);

   logic [XLEN-1:0] fetch_pc_r,    fetch_pc_n_s;
   logic [XLEN-1:0] resp_pc_r,     resp_pc_n_s;
   logic [OW-1:0]   outstanding_r, outstanding_n_s;
   logic [OW-1:0]   discard_r,     discard_n_s;
   logic [XLEN-1:0] resp_pc_p4_s;
   logic [CW-1:0]   fifo_count_s;
   logic            fifo_full_s;
   fq_entry_t       head_s;
   fq_entry_t       push_entry_s;
   logic            credit_s;
   logic            fire_s;
   logic            rsp_s;
   logic            accept_s;
   logic            pop_s;
   logic            pred_taken_s;
   logic [XLEN-1:0] pred_target_s;

   // Request credit and response qualification. Responses arriving with
   // nothing outstanding (e.g. after a reset) are ignored.
   always_comb begin
      credit_s  = ((int'(fifo_count_s) + int'(outstanding_r)) < int'(DEPTH)) &&
                  (int'(outstanding_r) < int'(MAX_OUT));
      imem_req  = !rst && !redirect_valid && credit_s;
      imem_addr = fetch_pc_r;
      fire_s    = imem_req && imem_gnt;
      rsp_s     = imem_rvalid && (outstanding_r != {OW{1'b0}});
      accept_s  = rsp_s && (discard_r == {OW{1'b0}}) && !redirect_valid;
      resp_pc_p4_s = resp_pc_r + PC_STEP;
   end

   // Prediction for the word being pushed
   always_comb begin
      pred_taken_s  = 1'b0;
      pred_target_s = resp_pc_p4_s;
`ifdef PREDICT_EN
      if (accept_s && (imem_rdata[6:0] == OP_JAL)) begin
         pred_taken_s  = 1'b1;
         pred_target_s = resp_pc_r + j_imm(imem_rdata);
      end else if (accept_s && (imem_rdata[6:0] == OP_BRANCH) && imem_rdata[31]) begin
         pred_taken_s  = 1'b1;
         pred_target_s = resp_pc_r + b_imm(imem_rdata);
      end else begin
         pred_taken_s  = 1'b0;
         pred_target_s = resp_pc_p4_s;
      end
`endif
      push_entry_s = '{instr: imem_rdata, pc: resp_pc_r,
                       pred_taken: pred_taken_s, pred_target: pred_target_s};
   end

   // Next fetch/response PCs and in-flight bookkeeping. On any re-steer every
   // request still outstanding afterwards is stale, so discard tracks it.
   always_comb begin
      case ({fire_s, rsp_s})
         2'b10:   outstanding_n_s = outstanding_r + OUT_ONE;
         2'b01:   outstanding_n_s = outstanding_r - OUT_ONE;
         default: outstanding_n_s = outstanding_r;
      endcase
      if (redirect_valid) begin
         fetch_pc_n_s = redirect_pc;
         resp_pc_n_s  = redirect_pc;
         discard_n_s  = outstanding_n_s;
      end else if (pred_taken_s) begin
         fetch_pc_n_s = pred_target_s;
         resp_pc_n_s  = pred_target_s;
         discard_n_s  = outstanding_n_s;
      end else begin
         fetch_pc_n_s = fire_s   ? fetch_pc_r + PC_STEP : fetch_pc_r;
         resp_pc_n_s  = accept_s ? resp_pc_p4_s         : resp_pc_r;
         if (rsp_s && (discard_r != {OW{1'b0}})) begin
            discard_n_s = discard_r - OUT_ONE;
         end else begin
            discard_n_s = discard_r;
         end
      end
   end

   // Fetch state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_r    <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         outstanding_r <= {OW{1'b0}};
         discard_r     <= {OW{1'b0}};
      end else begin
         fetch_pc_r    <= fetch_pc_n_s;
         resp_pc_r     <= resp_pc_n_s;
         outstanding_r <= outstanding_n_s;
         discard_r     <= discard_n_s;
      end
   end

   fq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect_valid),
      .push      (accept_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .head      (head_s),
      .count     (fifo_count_s),
      .full      (fifo_full_s)
   );

   fq_chk u_chk (
      .clk  (clk),
      .rst  (rst),
      .push (accept_s),
      .full (fifo_full_s)
   );

   // Decode-side view; the redirect cycle hides the head being flushed
   always_comb begin
      out_valid = (fifo_count_s != {CW{1'b0}}) && !redirect_valid;
      pop_s     = out_valid && out_ready;
      if (out_valid) begin
         out_instr      = head_s.instr;
         out_pc         = head_s.pc;
         out_pred_taken = head_s.pred_taken;
      end else begin
         out_instr      = NOP;
         out_pc         = {XLEN{1'b0}};
         out_pred_taken = 1'b0;
      end
      out_pc_p4       = out_pc + PC_STEP;
      out_pred_target = out_valid ? head_s.pred_target : out_pc_p4;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Randomized self-checking bench for fetch_queue. An instruction-memory model
// answers requests in order after a chosen latency; a scoreboard predicts the
// PC stream decode should see from the redirect/reset history alone.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam logic [31:0] NOP_W    = 32'h0000_0013;
   localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_p4;
   logic        out_pred_taken;
   logic [31:0] out_pred_target;

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_pc_p4(out_pc_p4),
      .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   pend_t       pend[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat = 1;
   int          fires = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_addr;
   logic [31:0] prev_fire_addr = 32'h0;
   logic [31:0] hold_addr = 32'h0;
   logic        hold_req = 1'b0;
   logic        saw_wrap = 1'b0;
   logic        saw_pred = 1'b0;
   logic        s_valid;
   logic        s_req;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Memory contents: a non-branch word that encodes its own address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
`ifdef PREDICT_EN
      if (a == 32'h0000_0040) return BEQ_M8;
`endif
      return {a[26:2], 7'h13};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; redirect_valid = 1'b0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; out_ready = 1'b0;
      #1;
      check_eq("rst_req",   {31'd0, imem_req},       32'd0);
      check_eq("rst_valid", {31'd0, out_valid},      32'd0);
      check_eq("rst_instr", out_instr,               NOP_W);
      check_eq("rst_pc",    out_pc,                  32'd0);
      check_eq("rst_pred",  {31'd0, out_pred_taken}, 32'd0);
      pend.delete();
      hold_req = 1'b0;
      exp_pc   = RESET_PC;
      exp_addr = RESET_PC;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
   endtask

   task automatic run_cycle(input logic redir, input logic [31:0] rpc,
                            input logic rdy, input int gnt_pct);
      logic        taken;
      logic [31:0] word;
      @(negedge clk);
      redirect_valid = redir;
      redirect_pc    = rpc;
      out_ready      = rdy;
      imem_gnt       = ($urandom_range(0, 99) < gnt_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      #1;
      if (redir) check_eq("valid_in_redirect", {31'd0, out_valid}, 32'd0);
`ifndef PREDICT_EN
      if (hold_req && !redir) begin
         check_eq("req_hold",  {31'd0, imem_req}, 32'd1);
         check_eq("addr_hold", imem_addr, hold_addr);
      end
`endif
      if (imem_req && imem_gnt) begin
`ifndef PREDICT_EN
         check_eq("req_addr", imem_addr, exp_addr);
`endif
         if (imem_addr == 32'h0 && prev_fire_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
         prev_fire_addr = imem_addr;
         exp_addr = exp_addr + 32'd4;
         pend.push_back('{imem_addr, cyc + lat});
         fires++;
         check_eq("outstanding_le_max", {31'd0, pend.size() <= int'(MAX_OUT)}, 32'd1);
      end
      hold_req  = imem_req && !imem_gnt;
      hold_addr = imem_addr;
      if (out_valid && rdy && !redir) begin
         word  = mem_word(exp_pc);
         taken = (word == BEQ_M8);
         check_eq("pop_pc",     out_pc,    exp_pc);
         check_eq("pop_instr",  out_instr, word);
         check_eq("pop_pc_p4",  out_pc_p4, exp_pc + 32'd4);
         check_eq("pop_pred",   {31'd0, out_pred_taken}, {31'd0, taken});
         check_eq("pop_target", out_pred_target, taken ? exp_pc - 32'd8 : exp_pc + 32'd4);
         if (taken) saw_pred = 1'b1;
         exp_pc = taken ? exp_pc - 32'd8 : exp_pc + 32'd4;
      end
      if (redir) begin
         exp_pc   = rpc;
         exp_addr = rpc;
      end
      s_valid = out_valid;
      s_req   = imem_req;
      @(posedge clk);
      cyc++;
   endtask

   initial begin
      int          f0;
      logic        r;
      logic        rdy;
      logic [31:0] rpc;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
      do_reset();

      // Straight-line stream from RESET_PC with single-cycle memory
      repeat (12) run_cycle(1'b0, 32'h0, 1'b1, 100);

      // Redirect to first valid output: 3 cycles with 1-cycle memory
      run_cycle(1'b1, 32'h0000_2000, 1'b1, 100);
      for (int k = 1; k <= 3; k++) begin
         run_cycle(1'b0, 32'h0, 1'b1, 100);
         check_eq("redir_latency", {31'd0, s_valid}, (k == 3) ? 32'd1 : 32'd0);
      end

      // Decode stalled: queue fills to DEPTH and requests stop
      run_cycle(1'b1, 32'h0000_1000, 1'b0, 100);
      f0 = fires;
      repeat (20) run_cycle(1'b0, 32'h0, 1'b0, 100);
      check_eq("held_entries", 32'(fires - f0), DEPTH);
      check_eq("req_when_full", {31'd0, s_req}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         run_cycle(1'b0, 32'h0, 1'b1, 100);
         check_eq("drain_valid", {31'd0, s_valid}, 32'd1);
      end

      // Redirect with requests in flight on a slower memory
      lat = 3;
      repeat (10) run_cycle(1'b0, 32'h0, 1'b1, 100);
      run_cycle(1'b1, 32'h0000_2000, 1'b1, 100);
      repeat (15) run_cycle(1'b0, 32'h0, 1'b1, 100);

      // Fetch address wraps past the top of the address space
      lat = 1;
      run_cycle(1'b1, 32'hFFFF_FFF0, 1'b1, 100);
      repeat (12) run_cycle(1'b0, 32'h0, 1'b1, 100);
      check_eq("addr_wrap", {31'd0, saw_wrap}, 32'd1);

`ifdef PREDICT_EN
      // Backward branch at 0x40 is predicted taken to 0x38
      run_cycle(1'b1, 32'h0000_0030, 1'b1, 100);
      repeat (20) run_cycle(1'b0, 32'h0, 1'b1, 100);
      check_eq("pred_seen", {31'd0, saw_pred}, 32'd1);
`endif

      // Random traffic: grants at 50%, random ready and redirects
      for (int seg = 1; seg <= 3; seg++) begin
         lat = seg;
         for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rpc = 32'($urandom_range(0, 1023)) << 2;
            run_cycle(r, rpc, rdy, 50);
         end
         if (seg == 2) do_reset();
      end
      repeat (30) run_cycle(1'b0, 32'h0, 1'b1, 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised front-end fetch unit. It generates sequential PCs and issues in-order read requests to instruction memory. Returned words are buffered with their PC in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. Redirects from execute flush the queue and discard in-flight responses; it replaces the single-slot fetch stage feeding decode.

Parameters:
XLEN, 32, PC/instruction width (32 only; 64 reserved)
DEPTH, 4, FIFO entries (power of 2, 2..16)
MAX_OUT, 2, max outstanding imem requests (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
redirect_valid  in  1  branch/jump/mispredict redirect this cycle
redirect_pc  in  XLEN  redirect target (4-byte aligned)
imem_req  out  1  read request strobe
imem_addr  out  XLEN  request address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid, in request order
imem_rdata  in  32  response instruction word
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction (NOP 32'h0000_0013 when out_valid=0)
out_pc  out  XLEN  head PC
out_pc_p4  out  XLEN  out_pc + 4
out_pred_taken  out  1  prediction for head (0 without PREDICT_EN)
out_pred_target  out  XLEN  predicted target (out_pc_p4 without PREDICT_EN)

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0. Outputs: imem_req=0, out_valid=0, out_instr=NOP, out_pc=0, out_pred_taken=0. First request is issued the cycle after rst deasserts. A reset mid-operation drops all state; late responses are ignored because outstanding=0.
- Credit rule: imem_req=1 iff !redirect_valid && (fifo_count + outstanding) < DEPTH && outstanding < MAX_OUT. imem_addr=fetch_pc.
- Handshake imem: request holds addr stable until imem_gnt. On req&&gnt, outstanding+1 and fetch_pc += 4 (mod 2^XLEN, wraps silently). Response latency is ≥1 cycle and in order.
- Response: on imem_rvalid, outstanding-1. If discard>0, drop the word and discard-1. Otherwise push {instr, pc} to the FIFO, with pc from an internal resp_pc that advances by 4. A push never overflows, guaranteed by the credit rule; assert in sim.
- Decode handshake: pop on out_valid&&out_ready. Simultaneous push and pop in one cycle keeps count unchanged. Full FIFO with a pop frees a credit the next cycle, not the same cycle.
- Redirect (highest priority, single cycle): FIFO cleared, and out_valid=0 in that same cycle. fetch_pc and resp_pc are set to redirect_pc. discard = outstanding - (rvalid this cycle ? 1:0), and any response in the redirect cycle is dropped. No request is issued that cycle. A redirect while discard>0 accumulates correctly.
- Any pop in the redirect cycle is ignored (decode is flushed by the same redirect).
- Latency: redirect to first out_valid = 1 + imem latency + 1 cycles (3 with 1-cycle imem).
- out_valid is registered from FIFO non-empty; no combinational path from imem_rdata to out_*.

Optional Feature:
PREDICT_EN:
- Defined: a static BTFN predictor is applied at push time. JAL is taken with target pc+J-imm. B-type with negative offset is taken with target pc+B-imm. Everything else is not-taken.
- On predicted taken, the entry is pushed with prediction fields, and the fetch front acts as an internal redirect to the target: same-cycle younger responses and outstanding are discarded as for redirect_valid, except the FIFO is kept.
- Undefined: out_pred_taken=0, out_pred_target=out_pc_p4, no internal redirects, no extra logic.

Decomposition:
- Shared package (defines): NOP encoding, opcode constants (OP_JAL, OP_BRANCH), fq_entry_t struct {instr, pc, pred_taken, pred_target}, imm extraction functions.
- Sub-module fq_fifo (DEPTH-entry circular buffer, push/pop/clear, count). Predictor logic stays inline.

Test Plan:
- Reset, RESET_PC=0x100, imem 1-cycle, gnt=1, ready=1 -> out_pc sequence 0x100,0x104,0x108 from cycle 3; out_pc_p4 = out_pc+4.
- ready=0 for 20 cycles -> exactly DEPTH=4 entries held, imem_req=0 once full; release -> 4 pops in order, no loss or duplicate.
- Redirect to 0x2000 with 2 outstanding -> both stale responses dropped; next out_pc=0x2000, 3 cycles after redirect.
- imem_gnt random 50%, 3-cycle response latency -> outstanding never exceeds MAX_OUT=2; PCs strictly +4 in order.
- fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000 (wrap).
- PREDICT_EN: word BEQ with offset -8 at 0x40 -> out_pred_taken=1, out_pred_target=0x38, next out_pc=0x38; ADDI -> pred_taken=0.
